ddfs_freq_meter: RTL and testbench

Measures the output period of the DDFS by timing rising mid-level crossings of its 8-bit sample stream. Sits directly downstream of `ddfs`, consuming its `q` output on the same clock. It reports a period averaged over 2^AVG_LOG2 cycles of the waveform. It also flags loss of signal, so the tuning word can be closed-loop checked in system and in simulation.

---
 rtl/ddfs_freq_meter.sv | 166 ++++++++++++++++
 tb/tb_ddfs_freq_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ddfs_freq_meter.sv
// Period meter for the DDFS sample stream: Schmitt-triggered rising mid-level
// crossings are timed and averaged over 2**AVG_LOG2 waveform periods.
module ddfs_freq_meter #(
  parameter int DATA_W   = 8,
  parameter int MID      = 128,
  parameter int HYST     = 4,
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] q_in,
  input  logic              enable,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_valid,
  output logic              locked,
  output logic              no_signal
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam logic [DATA_W-1:0]   HI_TH   = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0]   LO_TH   = DATA_W'(MID - HYST);
  localparam logic [CNT_W-1:0]    CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [AVG_LOG2-1:0] K_LAST  = '1;

  typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} level_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE} state_e;

  logic [DATA_W-1:0]   q_r_q;
  level_e              level_q, level_d;
  logic                event_q, event_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] k_q, k_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                no_signal_q, no_signal_d;

  logic [SUM_W-1:0]    sum_ext;
  logic                timeout;

  assign sum_ext = sum_q + SUM_W'(cnt_q);
  assign timeout = (cnt_q == CNT_TO);

  // Schmitt comparator; only a LOW->HIGH move is an event, so the first
  // qualifying sample after UNKNOWN just establishes the level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    event_d = 1'b0;
    if (!enable) begin
      level_d = LVL_UNKNOWN;
    end else if (q_r_q >= HI_TH) begin
      level_d = LVL_HIGH;
      event_d = (level_q == LVL_LOW);
    end else if (q_r_q < LO_TH) begin
      level_d = LVL_LOW;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    k_d         = k_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    no_signal_d = no_signal_q;

    if (!enable) begin
      // Disable outranks both event and timeout; results are left untouched.
      state_d = ST_IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = CNT_W'(1);
          sum_d   = '0;
          k_d     = '0;
        end
        ST_ARM: begin
          if (event_q) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_W'(1);
            sum_d   = '0;
            k_d     = '0;
          end else if (timeout) begin
            no_signal_d = 1'b1;
            locked_d    = 1'b0;
            cnt_d       = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (event_q) begin
            cnt_d = CNT_W'(1);
            if (k_q == K_LAST) begin
              period_d    = CNT_W'(sum_ext >> AVG_LOG2);
              valid_d     = 1'b1;
              locked_d    = 1'b1;
              no_signal_d = 1'b0;
              sum_d       = '0;
              k_d         = '0;
            end else begin
              sum_d = sum_ext;
              k_d   = k_q + AVG_LOG2'(1);
            end
          end else if (timeout) begin
            state_d     = ST_ARM;
            no_signal_d = 1'b1;
            locked_d    = 1'b0;
            cnt_d       = CNT_W'(1);
            sum_d       = '0;
            k_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r_q       <= '0;
      level_q     <= LVL_UNKNOWN;
      event_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      q_r_q       <= q_in;
      level_q     <= level_d;
      event_q     <= event_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      no_signal_q <= no_signal_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Scoreboard bench for ddfs_freq_meter: stimulus pushes expected periods,
// a negedge monitor pops and compares on every period_valid pulse.
module tb_ddfs_freq_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 1000;

  logic             clk;
  logic             reset;
  logic [7:0]       q_in;
  logic             enable;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             no_signal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  longint      cyc = 0;
  int unsigned exp_q[$];
  longint      pulse_cyc[$];
  logic        prev_valid = 1'b0;

  ddfs_freq_meter #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .enable       (enable),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .no_signal    (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    cyc++;
    if (!reset && period_valid) begin
      pulse_cyc.push_back(cyc);
      if (prev_valid) check("valid_one_cycle", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", period_out, 0);
        check("unexpected_valid_count", 1, 0);
      end else begin
        automatic int unsigned e = exp_q.pop_front();
        check("period_out", period_out, e);
        check("locked_at_valid", locked, 1);
        check("no_signal_at_valid", no_signal, 0);
      end
    end
    prev_valid = period_valid;
  end

  task automatic drive(input logic [7:0] v, input int n);
    repeat (n) begin
      q_in = v;
      @(negedge clk);
    end
  endtask

  // One waveform period: the rise at its start is the event, length hi+lo.
  task automatic square(input int hi, input int lo);
    drive(8'd200, hi);
    drive(8'd50, lo);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    drive(8'd50, 4);
  endtask

  logic [15:0] acc;
  logic [7:0]  jit [6] = '{8'd126, 8'd131, 8'd127, 8'd130, 8'd128, 8'd129};

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    q_in   = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_period_out", period_out, 0);
    check("rst_period_valid", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_no_signal", no_signal, 0);
    reset = 1'b0;
    drive(8'd0, 2);

    // DDFS loopback: 16-bit accumulator, tuning word 256 -> 256 clk/period.
    pulse_cyc.delete();
    exp_q.push_back(256);
    exp_q.push_back(256);
    acc    = '0;
    enable = 1'b1;
    for (int i = 0; i < 2400; i++) begin
      q_in = acc[15:8];
      acc  = acc + 16'd256;
      @(negedge clk);
    end
    check("ddfs_pulse_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() >= 2) check("ddfs_repeat_cycles", pulse_cyc[1] - pulse_cyc[0], 1024);
    go_idle();

    // Square 10/10 then 13/12 aligned to the averaging window: 20, 20, 25.
    exp_q.push_back(20);
    exp_q.push_back(20);
    exp_q.push_back(25);
    enable = 1'b1;
    drive(8'd50, 5);
    repeat (8) square(10, 10);
    repeat (4) square(13, 12);
    drive(8'd200, 10);
    go_idle();

    // Periods 10, 11, 11, 11 -> 43 >> 2 = 10.
    exp_q.push_back(10);
    enable = 1'b1;
    drive(8'd50, 5);
    square(5, 5);
    repeat (3) square(6, 5);
    drive(8'd200, 10);
    go_idle();

    // Jitter within the hysteresis band: ARM entered on the first enabled
    // edge, timeout lands TIMEOUT cycles after that.
    enable = 1'b1;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      q_in = jit[i % 6];
      @(negedge clk);
      if (i == TIMEOUT) check("no_signal_before_timeout", no_signal, 0);
    end
    check("no_signal_at_timeout", no_signal, 1);
    check("locked_cleared_by_timeout", locked, 0);
    check("period_held_on_timeout", period_out, 10);
    for (int i = 0; i < 100; i++) begin
      q_in = jit[i % 6];
      @(negedge clk);
    end
    check("no_signal_sticky", no_signal, 1);
    exp_q.push_back(40);
    drive(8'd50, 5);
    repeat (4) square(20, 20);
    drive(8'd200, 10);
    check("no_signal_cleared", no_signal, 0);
    go_idle();

    // Reset with k=2 (three events seen), then a fresh 15/15 run.
    enable = 1'b1;
    drive(8'd50, 5);
    repeat (3) square(10, 10);
    #2 reset = 1'b1;
    #1;
    check("midrst_period_out", period_out, 0);
    check("midrst_period_valid", period_valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_no_signal", no_signal, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(30);
    drive(8'd50, 5);
    repeat (8) square(15, 15);

    // k=3 now: the next rise would complete a result, but enable is low.
    enable = 1'b0;
    drive(8'd200, 3);
    check("drop_locked_held", locked, 1);
    check("drop_period_held", period_out, 30);
    check("drop_no_signal_held", no_signal, 0);
    enable = 1'b1;
    exp_q.push_back(16);
    drive(8'd50, 5);
    repeat (4) square(8, 8);
    drive(8'd200, 10);
    go_idle();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
